// File: rtl/rename_regfile_pkg.sv
// Shared widths for the rename register file.
// Optional busy counter is enabled by defining REGFILE_BUSY_CNT_EN.
package rename_regfile_pkg;

    localparam int REG_POS_WID = 5;
    localparam int DATA_WID    = 32;
    localparam int ROB_POS_WID = 4;
    localparam int REG_SIZE    = 32;

endpackage

// File: rtl/rename_regfile_rf_read_port.sv
// One combinational operand lookup: x0, intra-bundle rename, commit forward, table.
module rf_read_port
    import rename_regfile_pkg::*;
#(
    parameter int ISSUE_W    = 2,
    parameter int COMMIT_W   = 2,
    parameter int DATA_W     = 32,
    parameter int ROB_ADDR_W = 4,
    parameter int SLOT       = 0
) (
    input  logic [REG_POS_WID-1:0]          rs,
    input  logic [ISSUE_W-1:0]              issue,
    input  logic [ISSUE_W*REG_POS_WID-1:0]  issue_rd,
    input  logic [ISSUE_W*ROB_ADDR_W-1:0]   issue_rob_pos,
    input  logic [COMMIT_W-1:0]             commit,
    input  logic [COMMIT_W*ROB_ADDR_W-1:0]  commit_rob_pos,
    input  logic [COMMIT_W*DATA_W-1:0]      commit_val,
    input  logic [DATA_W-1:0]               entry_val,
    input  logic                            entry_busy,
    input  logic [ROB_ADDR_W-1:0]           entry_pos,
    output logic [DATA_W-1:0]               val,
    output logic [ROB_ADDR_W:0]             tag
);

    logic                  bundle_hit_s;
    logic [ROB_ADDR_W-1:0] bundle_pos_s;
    logic                  commit_hit_s;
    logic [DATA_W-1:0]     commit_fwd_s;

    // Youngest older slot in this bundle renaming rs, and a commit retiring the producer
    always_comb begin
        bundle_hit_s = 1'b0;
        bundle_pos_s = '0;
        commit_hit_s = 1'b0;
        commit_fwd_s = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            if ((j < SLOT) && issue[j] && (issue_rd[j*REG_POS_WID +: REG_POS_WID] == rs)) begin
                bundle_hit_s = 1'b1;
                bundle_pos_s = issue_rob_pos[j*ROB_ADDR_W +: ROB_ADDR_W];
            end else begin
                bundle_hit_s = bundle_hit_s;
            end
        end
        for (int c = 0; c < COMMIT_W; c++) begin
            if (commit[c] && entry_busy &&
                (commit_rob_pos[c*ROB_ADDR_W +: ROB_ADDR_W] == entry_pos)) begin
                commit_hit_s = 1'b1;
                commit_fwd_s = commit_val[c*DATA_W +: DATA_W];
            end else begin
                commit_hit_s = commit_hit_s;
            end
        end
    end

    // Priority select of the operand
    always_comb begin
        val = '0;
        tag = '0;
        if (rs == {REG_POS_WID{1'b0}}) begin
            val = '0;
            tag = '0;
        end else if (bundle_hit_s) begin
            val = '0;
            tag = {1'b1, bundle_pos_s};
        end else if (commit_hit_s) begin
            val = commit_fwd_s;
            tag = '0;
        end else begin
            val = entry_val;
            tag = entry_busy ? {1'b1, entry_pos} : {(ROB_ADDR_W+1){1'b0}};
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags, multi-slot issue/commit and flush.
// Define REGFILE_BUSY_CNT_EN to add the registered busy_cnt output.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int ISSUE_W    = 2,
    parameter int COMMIT_W   = 2,
    parameter int DATA_W     = DATA_WID,
    parameter int NREGS      = REG_SIZE,
    parameter int ROB_ADDR_W = ROB_POS_WID
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rdy,
    input  logic [ISSUE_W*REG_POS_WID-1:0]      rs1,
    input  logic [ISSUE_W*REG_POS_WID-1:0]      rs2,
    output logic [ISSUE_W*DATA_W-1:0]           val1,
    output logic [ISSUE_W*DATA_W-1:0]           val2,
    output logic [ISSUE_W*(ROB_ADDR_W+1)-1:0]   tag1,
    output logic [ISSUE_W*(ROB_ADDR_W+1)-1:0]   tag2,
    input  logic [ISSUE_W-1:0]                  issue,
    input  logic [ISSUE_W*REG_POS_WID-1:0]      issue_rd,
    input  logic [ISSUE_W*ROB_ADDR_W-1:0]       issue_rob_pos,
    input  logic [COMMIT_W-1:0]                 commit,
    input  logic [COMMIT_W*REG_POS_WID-1:0]     commit_rd,
    input  logic [COMMIT_W*ROB_ADDR_W-1:0]      commit_rob_pos,
    input  logic [COMMIT_W*DATA_W-1:0]          commit_val,
    input  logic                                flush
`ifdef REGFILE_BUSY_CNT_EN
    ,
    output logic [$clog2(NREGS+1)-1:0]          busy_cnt
`endif
);

    localparam int TAG_W = ROB_ADDR_W + 1;

    logic [DATA_W-1:0]     val_r  [NREGS];
    logic [DATA_W-1:0]     val_s  [NREGS];
    logic [ROB_ADDR_W-1:0] pos_r  [NREGS];
    logic [ROB_ADDR_W-1:0] pos_s  [NREGS];
    logic [NREGS-1:0]      busy_r;
    logic [NREGS-1:0]      busy_s;

    // Next table state: commits first, then flush or issues override busy/pos
    always_comb begin
        val_s  = val_r;
        pos_s  = pos_r;
        busy_s = busy_r;
        for (int c = 0; c < COMMIT_W; c++) begin
            if (commit[c] && (commit_rd[c*REG_POS_WID +: REG_POS_WID] != {REG_POS_WID{1'b0}})) begin
                val_s[commit_rd[c*REG_POS_WID +: REG_POS_WID]] = commit_val[c*DATA_W +: DATA_W];
                // Only the commit of the current producer releases the register
                if (busy_r[commit_rd[c*REG_POS_WID +: REG_POS_WID]] &&
                    (pos_r[commit_rd[c*REG_POS_WID +: REG_POS_WID]] ==
                     commit_rob_pos[c*ROB_ADDR_W +: ROB_ADDR_W])) begin
                    busy_s[commit_rd[c*REG_POS_WID +: REG_POS_WID]] = 1'b0;
                end else begin
                    busy_s = busy_s;
                end
            end else begin
                val_s = val_s;
            end
        end
        if (flush) begin
            busy_s = '0;
        end else begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (issue[k] && (issue_rd[k*REG_POS_WID +: REG_POS_WID] != {REG_POS_WID{1'b0}})) begin
                    busy_s[issue_rd[k*REG_POS_WID +: REG_POS_WID]] = 1'b1;
                    pos_s[issue_rd[k*REG_POS_WID +: REG_POS_WID]]  =
                        issue_rob_pos[k*ROB_ADDR_W +: ROB_ADDR_W];
                end else begin
                    busy_s = busy_s;
                end
            end
        end
    end

    // Table registers; rdy=0 freezes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                val_r[i] <= '0;
                pos_r[i] <= '0;
            end
            busy_r <= '0;
        end else if (rdy) begin
            val_r  <= val_s;
            pos_r  <= pos_s;
            busy_r <= busy_s;
        end
    end

`ifdef REGFILE_BUSY_CNT_EN
    localparam int CNT_W = $clog2(NREGS+1);

    function automatic logic [CNT_W-1:0] count_busy(input logic [NREGS-1:0] b);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NREGS; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, b[i]};
        end
        return n;
    endfunction

    // Counter tracks the popcount of the busy bits being registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= '0;
        end else if (rdy) begin
            busy_cnt <= count_busy(busy_s);
        end
    end
`endif

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
        logic [REG_POS_WID-1:0] a_s;
        logic [REG_POS_WID-1:0] b_s;
        assign a_s = rs1[k*REG_POS_WID +: REG_POS_WID];
        assign b_s = rs2[k*REG_POS_WID +: REG_POS_WID];

        rf_read_port #(
            .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W),
            .ROB_ADDR_W(ROB_ADDR_W), .SLOT(k)
        ) u_rd1 (
            .rs(a_s), .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
            .commit(commit), .commit_rob_pos(commit_rob_pos), .commit_val(commit_val),
            .entry_val(val_r[a_s]), .entry_busy(busy_r[a_s]), .entry_pos(pos_r[a_s]),
            .val(val1[k*DATA_W +: DATA_W]), .tag(tag1[k*TAG_W +: TAG_W])
        );

        rf_read_port #(
            .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W),
            .ROB_ADDR_W(ROB_ADDR_W), .SLOT(k)
        ) u_rd2 (
            .rs(b_s), .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
            .commit(commit), .commit_rob_pos(commit_rob_pos), .commit_val(commit_val),
            .entry_val(val_r[b_s]), .entry_busy(busy_r[b_s]), .entry_pos(pos_r[b_s]),
            .val(val2[k*DATA_W +: DATA_W]), .tag(tag2[k*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile; busy_cnt checked when REGFILE_BUSY_CNT_EN is defined.
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [9:0]  rs1, rs2;
    logic [63:0] val1, val2;
    logic [9:0]  tag1, tag2;
    logic [1:0]  issue;
    logic [9:0]  issue_rd;
    logic [7:0]  issue_rob_pos;
    logic [1:0]  commit;
    logic [9:0]  commit_rd;
    logic [7:0]  commit_rob_pos;
    logic [63:0] commit_val;
    logic        flush;
`ifdef REGFILE_BUSY_CNT_EN
    logic [5:0]  busy_cnt;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rename_regfile dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rs1(rs1), .rs2(rs2), .val1(val1), .val2(val2), .tag1(tag1), .tag2(tag2),
        .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
        .commit(commit), .commit_rd(commit_rd), .commit_rob_pos(commit_rob_pos),
        .commit_val(commit_val), .flush(flush)
`ifdef REGFILE_BUSY_CNT_EN
        , .busy_cnt(busy_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic idle();
        rdy = 1'b1; issue = '0; issue_rd = '0; issue_rob_pos = '0;
        commit = '0; commit_rd = '0; commit_rob_pos = '0; commit_val = '0;
        flush = 1'b0; rs1 = '0; rs2 = '0;
    endtask

    task automatic do_issue(input int k, input logic [4:0] rd, input logic [3:0] pos);
        issue[k] = 1'b1;
        issue_rd[k*5 +: 5] = rd;
        issue_rob_pos[k*4 +: 4] = pos;
    endtask

    task automatic do_commit(input int k, input logic [4:0] rd, input logic [3:0] pos,
                             input logic [31:0] v);
        commit[k] = 1'b1;
        commit_rd[k*5 +: 5] = rd;
        commit_rob_pos[k*4 +: 4] = pos;
        commit_val[k*32 +: 32] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        rs1[4:0] = 5'd5;
        #2;
        check("reset_val", val1[31:0], 32'h0);
        check("reset_tag", {27'd0, tag1[4:0]}, 32'h0);
        #1 rst = 1'b1;

        // Rename x5 -> rob 3, then commit-forward
        step(); do_issue(0, 5'd5, 4'd3);
        step(); idle(); rs1[4:0] = 5'd5; #1;
        check("rename_tag", {27'd0, tag1[4:0]}, 32'h13);
        do_commit(0, 5'd5, 4'd3, 32'hDEAD); #1;
        check("fwd_val", val1[31:0], 32'hDEAD);
        check("fwd_tag", {27'd0, tag1[4:0]}, 32'h0);
        step(); idle(); rs1[4:0] = 5'd5; #1;
        check("commit_val", val1[31:0], 32'hDEAD);
        check("commit_tag", {27'd0, tag1[4:0]}, 32'h0);

        // Stale commit of x7
        idle(); do_issue(0, 5'd7, 4'd2);
        step(); idle(); do_issue(0, 5'd7, 4'd6);
        step(); idle(); do_commit(0, 5'd7, 4'd2, 32'h11); rs1[4:0] = 5'd7; #1;
        check("stale_nofwd_tag", {27'd0, tag1[4:0]}, 32'h16);
        step(); idle(); rs1[4:0] = 5'd7; rs2[9:5] = 5'd7; #1;
        check("stale_tag", {27'd0, tag1[4:0]}, 32'h16);
        check("stale_val", val1[31:0], 32'h11);
        check("rs2_slot1_tag", {27'd0, tag2[9:5]}, 32'h16);

        // Intra-bundle rename of x9
        idle(); do_issue(0, 5'd9, 4'd4); rs1[4:0] = 5'd9; rs1[9:5] = 5'd9; #1;
        check("bundle_slot1_tag", {27'd0, tag1[9:5]}, 32'h14);
        check("bundle_slot0_tag", {27'd0, tag1[4:0]}, 32'h0);
        do_issue(1, 5'd9, 4'd5);
        step(); idle(); rs1[4:0] = 5'd9; #1;
        check("bundle_last_wins", {27'd0, tag1[4:0]}, 32'h15);

        // Six busy registers then flush with commit of x3
        idle(); do_issue(0, 5'd1, 4'd7); do_issue(1, 5'd2, 4'd8);
        step(); idle(); do_issue(0, 5'd3, 4'd9); do_issue(1, 5'd4, 4'd10);
        step(); idle();
`ifdef REGFILE_BUSY_CNT_EN
        check("busy_cnt_6", {26'd0, busy_cnt}, 32'd6);
`endif
        do_commit(0, 5'd3, 4'd0, 32'h42); do_issue(0, 5'd10, 4'd11); flush = 1'b1;
        step(); idle(); rs1[4:0] = 5'd3; rs1[9:5] = 5'd7; rs2[4:0] = 5'd9; rs2[9:5] = 5'd10; #1;
        check("flush_x3_val", val1[31:0], 32'h42);
        check("flush_x3_tag", {27'd0, tag1[4:0]}, 32'h0);
        check("flush_x7_tag", {27'd0, tag1[9:5]}, 32'h0);
        check("flush_x9_tag", {27'd0, tag2[4:0]}, 32'h0);
        check("flush_x10_tag", {27'd0, tag2[9:5]}, 32'h0);
`ifdef REGFILE_BUSY_CNT_EN
        check("busy_cnt_flush", {26'd0, busy_cnt}, 32'd0);
`endif

        // x0 is never written nor busy
        idle(); do_issue(0, 5'd0, 4'd1); do_commit(1, 5'd0, 4'd1, 32'hFFFF); rs1[9:5] = 5'd0; #1;
        check("x0_bundle_tag", {27'd0, tag1[9:5]}, 32'h0);
        step(); idle(); rs1[4:0] = 5'd0; #1;
        check("x0_val", val1[31:0], 32'h0);
        check("x0_tag", {27'd0, tag1[4:0]}, 32'h0);

        // rdy=0 freezes state, including flush
        idle(); do_issue(0, 5'd11, 4'd13);
        step(); idle(); rdy = 1'b0; do_issue(0, 5'd12, 4'd12);
        do_commit(0, 5'd3, 4'd0, 32'h99); flush = 1'b1;
        step(); idle(); rs1[4:0] = 5'd11; rs1[9:5] = 5'd12; rs2[4:0] = 5'd3; #1;
        check("rdy0_x11_tag", {27'd0, tag1[4:0]}, 32'h1D);
        check("rdy0_x12_tag", {27'd0, tag1[9:5]}, 32'h0);
        check("rdy0_x3_val", val2[31:0], 32'h42);
`ifdef REGFILE_BUSY_CNT_EN
        check("busy_cnt_rdy0", {26'd0, busy_cnt}, 32'd1);
`endif

        // Commit ordering and issue+commit on the same register
        idle(); do_commit(0, 5'd13, 4'd0, 32'hA); do_commit(1, 5'd13, 4'd1, 32'hB);
        do_issue(0, 5'd11, 4'd14); do_commit(0, 5'd11, 4'd13, 32'h77);
        do_commit(1, 5'd13, 4'd1, 32'hB);
        step(); idle(); rs1[4:0] = 5'd11; rs1[9:5] = 5'd13; #1;
        check("iss_com_tag", {27'd0, tag1[4:0]}, 32'h1E);
        check("iss_com_val", val1[31:0], 32'h77);
        check("commit_order", val1[63:32], 32'hB);
        idle(); do_commit(0, 5'd13, 4'd0, 32'hA); do_commit(1, 5'd13, 4'd1, 32'hC);
        step(); idle(); rs1[4:0] = 5'd13; #1;
        check("commit_hi_slot", val1[31:0], 32'hC);

        // Asynchronous reset mid-cycle with a bundle pending
        do_issue(0, 5'd13, 4'd2); do_commit(0, 5'd11, 4'd14, 32'h5); rs1[9:5] = 5'd11;
        rst = 1'b0; #1;
        check("arst_val", val1[31:0], 32'h0);
        check("arst_tag", {27'd0, tag1[9:5]}, 32'h0);
        idle(); #1 rst = 1'b1;
        step(); rs1[4:0] = 5'd13; rs1[9:5] = 5'd11; #1;
        check("arst_after_x13", val1[31:0], 32'h0);
        check("arst_after_x11", {27'd0, tag1[9:5]}, 32'h0);
`ifdef REGFILE_BUSY_CNT_EN
        check("busy_cnt_arst", {26'd0, busy_cnt}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
